uart_rx_deserializer: RTL

Receives 8N1 asynchronous serial data on the board's TTL RX pin and presents each byte on a parallel valid/ready interface for the top-level demo logic (LED drivers, loopback to TX). It sits directly behind the RX pad. It synchronises the raw line, validates the start bit at mid-bit and samples data LSB-first at bit centres. It also flags framing errors and overruns. At the default parameter it runs at 9600 baud from the 12 MHz board clock.

---
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 serial receiver with valid/ready byte output
//
// Purpose: synchronises the raw RX line, qualifies the start bit at mid-bit,
// samples eight data bits LSB-first at bit centres and checks the stop bit.
// Completed bytes are presented on a valid/ready interface.
//
// Ports:
//   iCE_CLK       system clock, rising edge
//   reset         asynchronous active-high reset
//   RS232_Rx_TTL  raw serial line, idles high, asynchronous to iCE_CLK
//   rx_data       received byte, stable while rx_valid=1
//   rx_valid      byte available, held until rx_valid & rx_ready at an edge
//   rx_ready      consumer accept
//   frame_err     one-cycle pulse when the stop bit samples low
//   overrun       one-cycle pulse when a byte completes while one is unaccepted
//   busy          high whenever the receiver is not idle

`timescale 1ns/1ps

module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       iCE_CLK,
    input  logic       reset,
    input  logic       RS232_Rx_TTL,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic         r_sync1;
    logic         r_sync2;
    logic [7:0]   r_rx_data;
    logic         r_rx_valid;
    logic         r_frame_err;
    logic         r_overrun;
    logic         r_busy;
    logic         w_rxs;

    assign w_rxs     = r_sync2;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

    always_ff @(posedge iCE_CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= RS232_Rx_TTL;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Handshake drops valid; a byte loading this same cycle re-asserts it below.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == LP_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            // Line already back high at mid start bit: treat as a glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (r_cnt == LP_BIT_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (r_cnt == LP_BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Leaving at mid stop bit lets a back-to-back start edge be seen in IDLE.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_rx_valid || rx_ready) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end

                S_WAIT_HIGH: begin
                    // A held-low (break) line is ignored until it returns to idle.
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
